// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-deep holding register
//
// Purpose
//   Serialises 8-bit bytes onto the TX line as 8N1 frames (start 0, data LSB
//   first, stop 1). A one-byte holding register lets the host queue the next
//   byte while a frame is in flight, so back-to-back bytes leave with no idle
//   gap between the stop bit of one frame and the start bit of the next.
//
// Parameters
//   BAUD_CLKS  clk cycles per bit period, 2..63 (6-bit baud counter)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   trmt      in   transmit request, accepted on any edge where tx_rdy=1
//   tx_data   in   byte to send, sampled only on the accepting edge
//   clr_done  in   clears tx_done
//   TX        out  serial line, idle high
//   tx_rdy    out  holding register empty, trmt will be accepted
//   tx_busy   out  frame in progress
//   tx_done   out  sticky: last queued byte fully sent, line idle

module uart_tx #(
    parameter int BAUD_CLKS = 34
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    input  logic       clr_done,
    output logic       TX,
    output logic       tx_rdy,
    output logic       tx_busy,
    output logic       tx_done
);

    if (BAUD_CLKS < 2 || BAUD_CLKS > 63) begin : g_bad_baud
        $error("uart_tx: BAUD_CLKS must be in 2..63");
    end

    localparam logic [5:0] BAUD_LAST = 6'(BAUD_CLKS - 1);
    localparam logic [3:0] BIT_LAST  = 4'd9;

    typedef enum logic {
        IDLE,
        TRANSMIT
    } state_t;

    state_t     state_q;
    logic [5:0] baud_cnt_q;
    logic [3:0] bit_cnt_q;
    logic [8:0] shift_q;
    logic [7:0] hold_q;
    logic       hold_full_q;
    logic       tx_done_q;

    // Shift pulse only exists while transmitting, so the counters can never
    // produce a spurious shift in IDLE.
    logic shift_pulse;
    logic frame_end;
    logic hold_accept;

    assign shift_pulse = (state_q == TRANSMIT) && (baud_cnt_q == BAUD_LAST);
    // Terminal shift of the stop bit: the whole 10-bit frame is on the wire.
    assign frame_end   = shift_pulse && (bit_cnt_q == BIT_LAST);
    assign hold_accept = trmt && !hold_full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            // All ones so the line sits high (idle) straight out of reset.
            shift_q     <= '1;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trmt) begin
                        // Start bit appears on the accepting edge.
                        shift_q    <= {tx_data, 1'b0};
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_done_q  <= 1'b0;
                        state_q    <= TRANSMIT;
                    end else if (clr_done) begin
                        tx_done_q <= 1'b0;
                    end
                end

                TRANSMIT: begin
                    if (frame_end) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        if (hold_full_q) begin
                            // Queued byte starts on this very edge: zero gap.
                            // A trmt seen now is ignored because tx_rdy=0.
                            shift_q     <= {hold_q, 1'b0};
                            hold_full_q <= 1'b0;
                            if (clr_done) begin
                                tx_done_q <= 1'b0;
                            end
                        end else if (trmt) begin
                            // Late request landing exactly on the frame end
                            // bypasses the hold register.
                            shift_q   <= {tx_data, 1'b0};
                            tx_done_q <= 1'b0;
                        end else begin
                            // Setting done wins over a coincident clr_done.
                            shift_q   <= '1;
                            tx_done_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end else begin
                        if (shift_pulse) begin
                            shift_q    <= {1'b1, shift_q[8:1]};
                            baud_cnt_q <= '0;
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                        end else begin
                            baud_cnt_q <= baud_cnt_q + 6'd1;
                        end

                        if (hold_accept) begin
                            hold_q      <= tx_data;
                            hold_full_q <= 1'b1;
                            tx_done_q   <= 1'b0;
                        end else if (clr_done) begin
                            tx_done_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    shift_q <= '1;
                end
            endcase
        end
    end

    // shift_q is a flop, so TX is glitch-free and registered.
    assign TX      = shift_q[0];
    assign tx_rdy  = ~hold_full_q;
    assign tx_busy = (state_q == TRANSMIT);
    assign tx_done = tx_done_q;

endmodule
